// File: rtl/contra_pkg.sv
// contra_pkg
// Shared definitions for the contrast-parameter controller: FSM state
// encoding, accumulator reload constants, saturation limits and the
// range clamp helper used when publishing.
package contra_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_OFFER  = 2'd3
    } state_t;

    // Running-min starts at the top of the range, running-max at the bottom,
    // so the first DE pixel of a frame overwrites both.
    localparam logic [7:0]  ACC_MIN_INIT = 8'd255;
    localparam logic [7:0]  ACC_MAX_INIT = 8'd0;

    localparam logic [15:0] PIX_CNT_MAX  = 16'hFFFF;
    localparam logic [7:0]  DROP_CNT_MAX = 8'd255;

    // smax - smin, forced up to floor_val when smaller. The difference is
    // taken in 9-bit signed so a smoothed max that has fallen below the
    // smoothed min clamps instead of wrapping.
    function automatic logic [7:0] range_clamp(
        input logic [7:0] smax,
        input logic [7:0] smin,
        input logic [7:0] floor_val
    );
        logic signed [8:0] diff;
        diff = $signed({1'b0, smax}) - $signed({1'b0, smin});
        if (diff < $signed({1'b0, floor_val}))
            return floor_val;
        return diff[7:0];
    endfunction

endpackage

// File: rtl/contra_iir_step.sv
// contra_iir_step
// One step of the first-order smoothing filter, purely combinational:
//   result = old_val + ((meas - old_val) >>> SHIFT)
// Ports:
//   old_val  in  8  current smoothed value
//   meas     in  8  new measurement
//   result   out 8  updated smoothed value
// The difference is 9-bit signed and shifted arithmetically (rounds toward
// minus infinity). The result always lies between old_val and meas, so it
// fits back into 8 bits.
module contra_iir_step #(
    parameter int SHIFT = 2
) (
    input  logic [7:0] old_val,
    input  logic [7:0] meas,
    output logic [7:0] result
);

    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [8:0] sum;

    always_comb begin
        diff   = $signed({1'b0, meas}) - $signed({1'b0, old_val});
        step   = diff >>> SHIFT;
        sum    = $signed({1'b0, old_val}) + step;
        result = 8'(sum);
    end

endmodule

// File: rtl/contra_param_ctrl.sv
// contra_param_ctrl
// Measures per-frame black level (min) and max intensity of a pixel stream,
// temporally smooths them, and offers {min, max-min} to a consumer with a
// valid/ack handshake. Frames that close while an offer is still pending
// are dropped and counted.
//
// Ports:
//   isrc_clk      in   1  pixel clock, everything on its rising edge
//   irst_n        in   1  asynchronous active-low reset
//   isrc_data     in   8  pixel intensity
//   isrc_vs       in   1  vertical sync (active level = POLARITY)
//   isrc_de       in   1  pixel valid
//   ienable       in   1  commit enable, sampled on the frame strobe
//   omin          out  8  published black level
//   orange        out  8  published range (>= MIN_RANGE)
//   oparam_valid  out  1  parameters offered
//   iparam_ack    in   1  consumer accept
//   odrop_cnt     out  8  saturating dropped-frame count
//   obusy         out  1  high in COMMIT / OFFER
//
// state  | meaning
// IDLE   | after reset, waiting for the first frame start
// ACCUM  | accumulating min/max/count of the current frame
// COMMIT | one cycle: smooth captured stats, load output registers
// OFFER  | oparam_valid high, waiting for iparam_ack
module contra_param_ctrl
    import contra_pkg::*;
#(
    parameter int POLARITY     = 1,
    parameter int SMOOTH_SHIFT = 2,
    parameter int MIN_PIXELS   = 16,
    parameter int MIN_RANGE    = 1
) (
    input  logic       isrc_clk,
    input  logic       irst_n,
    input  logic [7:0] isrc_data,
    input  logic       isrc_vs,
    input  logic       isrc_de,
    input  logic       ienable,
    output logic [7:0] omin,
    output logic [7:0] orange,
    output logic       oparam_valid,
    input  logic       iparam_ack,
    output logic [7:0] odrop_cnt,
    output logic       obusy
);

    localparam logic        VS_ACTIVE   = (POLARITY != 0);
    localparam logic [15:0] MIN_PIX     = 16'(MIN_PIXELS);
    localparam logic [7:0]  RANGE_FLOOR = 8'(MIN_RANGE);

    state_t      state;
    state_t      state_nxt;

    logic        prev_vs;
    logic        strobe;

    logic [7:0]  acc_min;
    logic [7:0]  acc_max;
    logic [15:0] acc_cnt;

    logic [7:0]  meas_min;
    logic [7:0]  meas_max;
    logic [7:0]  smin;
    logic [7:0]  smax;
    logic        hist_vld;

    logic [7:0]  iir_min;
    logic [7:0]  iir_max;
    logic [7:0]  new_min;
    logic [7:0]  new_max;
    logic [7:0]  new_range;

    logic        commit_go;
    logic        hist_clr;
    logic        drop_evt;
    logic        xfer;

    // Frame start: active vs level now, inactive last cycle.
    assign strobe = (isrc_vs == VS_ACTIVE) && (prev_vs != VS_ACTIVE);

    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n)
            prev_vs <= 1'b0;
        else
            prev_vs <= isrc_vs;
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit_go = 1'b0;
        hist_clr  = 1'b0;
        drop_evt  = 1'b0;
        xfer      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (strobe)
                    state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (strobe) begin
                    if (!ienable) begin
                        hist_clr = 1'b1;
                    end else if (acc_cnt >= MIN_PIX && !oparam_valid) begin
                        commit_go = 1'b1;
                        state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_OFFER;
            end
            ST_OFFER: begin
                // A strobe on the transfer edge still sees OFFER, so it is a drop.
                drop_evt = strobe;
                if (oparam_valid && iparam_ack) begin
                    xfer      = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign obusy = (state == ST_COMMIT) || (state == ST_OFFER);

    // ---------------------------------------------------------------
    // Per-frame accumulators. The strobe-cycle pixel is never counted.
    // ---------------------------------------------------------------
    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n) begin
            acc_min <= ACC_MIN_INIT;
            acc_max <= ACC_MAX_INIT;
            acc_cnt <= '0;
        end else if (strobe) begin
            acc_min <= ACC_MIN_INIT;
            acc_max <= ACC_MAX_INIT;
            acc_cnt <= '0;
        end else if (state == ST_ACCUM && isrc_de) begin
            if (isrc_data < acc_min)
                acc_min <= isrc_data;
            if (isrc_data > acc_max)
                acc_max <= isrc_data;
            if (acc_cnt != PIX_CNT_MAX)
                acc_cnt <= acc_cnt + 16'd1;
        end
    end

    // Snapshot of the closing frame, taken on the strobe that starts COMMIT,
    // since the accumulators reload on that same edge.
    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n) begin
            meas_min <= '0;
            meas_max <= '0;
        end else if (commit_go) begin
            meas_min <= acc_min;
            meas_max <= acc_max;
        end
    end

    // ---------------------------------------------------------------
    // Smoothing and publish
    // ---------------------------------------------------------------
    contra_iir_step #(.SHIFT(SMOOTH_SHIFT)) u_iir_min (
        .old_val (smin),
        .meas    (meas_min),
        .result  (iir_min)
    );

    contra_iir_step #(.SHIFT(SMOOTH_SHIFT)) u_iir_max (
        .old_val (smax),
        .meas    (meas_max),
        .result  (iir_max)
    );

    // With no history the measurement seeds the filter directly.
    always_comb begin
        new_min   = hist_vld ? iir_min : meas_min;
        new_max   = hist_vld ? iir_max : meas_max;
        new_range = range_clamp(new_max, new_min, RANGE_FLOOR);
    end

    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n) begin
            smin     <= '0;
            smax     <= '0;
            hist_vld <= 1'b0;
        end else if (hist_clr) begin
            hist_vld <= 1'b0;
        end else if (state == ST_COMMIT) begin
            smin     <= new_min;
            smax     <= new_max;
            hist_vld <= 1'b1;
        end
    end

    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n) begin
            omin         <= '0;
            orange       <= RANGE_FLOOR;
            oparam_valid <= 1'b0;
        end else if (state == ST_COMMIT) begin
            omin         <= new_min;
            orange       <= new_range;
            oparam_valid <= 1'b1;
        end else if (xfer) begin
            oparam_valid <= 1'b0;
        end
    end

    always_ff @(posedge isrc_clk or negedge irst_n) begin
        if (!irst_n)
            odrop_cnt <= '0;
        else if (drop_evt && odrop_cnt != DROP_CNT_MAX)
            odrop_cnt <= odrop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_contra_param_ctrl.sv
module tb_contra_param_ctrl;

    logic       isrc_clk = 1'b0;
    logic       irst_n   = 1'b0;
    logic [7:0] isrc_data = 8'd0;
    logic       isrc_vs  = 1'b0;
    logic       isrc_de  = 1'b0;
    logic       ienable  = 1'b1;
    logic       iparam_ack = 1'b1;
    logic [7:0] omin;
    logic [7:0] orange;
    logic       oparam_valid;
    logic [7:0] odrop_cnt;
    logic       obusy;

    always #5 isrc_clk = ~isrc_clk;

    contra_param_ctrl dut (
        .isrc_clk     (isrc_clk),
        .irst_n       (irst_n),
        .isrc_data    (isrc_data),
        .isrc_vs      (isrc_vs),
        .isrc_de      (isrc_de),
        .ienable      (ienable),
        .omin         (omin),
        .orange       (orange),
        .oparam_valid (oparam_valid),
        .iparam_ack   (iparam_ack),
        .odrop_cnt    (odrop_cnt),
        .obusy        (obusy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int lo;
        int hi;
        int npx;
        bit en;
        bit pub;
        int exp_min;
        int exp_rng;
    } frame_rec_t;

    typedef struct {
        int mn;
        int rg;
    } pub_t;

    frame_rec_t tbl[10];
    pub_t       sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every transfer (valid && ack, sampled mid-cycle) pops one
    // expected publication.
    always @(negedge isrc_clk) begin
        if (irst_n && oparam_valid && iparam_ack) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_publish: got omin=%0d orange=%0d expected none", omin, orange);
            end else begin
                pub_t e;
                e = sb_q.pop_front();
                check("pub_omin", int'(omin), e.mn);
                check("pub_orange", int'(orange), e.rg);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge isrc_clk);
        #1;
    endtask

    // One-cycle frame strobe; a DE pixel of value 0 rides on the strobe
    // cycle and must never reach the accumulators.
    task automatic strobe(input bit en);
        tick();
        isrc_vs   = 1'b1;
        ienable   = en;
        isrc_de   = 1'b1;
        isrc_data = 8'd0;
        tick();
        isrc_vs   = 1'b0;
        isrc_de   = 1'b0;
    endtask

    task automatic pixels(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            isrc_de   = 1'b1;
            isrc_data = 8'((n > 1) ? lo + ((hi - lo) * i) / (n - 1) : lo);
        end
        tick();
        isrc_de = 1'b0;
    endtask

    // With ack high: COMMIT one cycle after strobe, valid for exactly one cycle.
    task automatic post_strobe(input string tag, input bit pub);
        @(negedge isrc_clk);
        check({tag, "_busy"}, int'(obusy), int'(pub));
        @(negedge isrc_clk);
        check({tag, "_valid"}, int'(oparam_valid), int'(pub));
        @(negedge isrc_clk);
        check({tag, "_valid_low"}, int'(oparam_valid), 0);
    endtask

    initial begin
        //            lo   hi  npx en pub  min  rng
        tbl[0] = '{  40, 200, 64, 1, 1,  40, 160};
        tbl[1] = '{   0, 255, 64, 0, 0,   0,   0};
        tbl[2] = '{   0, 255, 64, 1, 1,   0, 255};
        tbl[3] = '{ 100, 200, 64, 1, 1,  25, 216};
        tbl[4] = '{   0, 255, 10, 1, 0,   0,   0};
        tbl[5] = '{ 120, 160, 64, 1, 1,  48, 172};
        tbl[6] = '{   0, 255, 30, 0, 0,   0,   0};
        tbl[7] = '{  77,  77, 16, 1, 1,  77,   1};
        tbl[8] = '{   5,   5, 15, 1, 0,   0,   0};
        tbl[9] = '{ 200, 200, 16, 1, 1, 107,   1};

        #12;
        check("rst_omin",   int'(omin), 0);
        check("rst_orange", int'(orange), 1);
        check("rst_valid",  int'(oparam_valid), 0);
        check("rst_drop",   int'(odrop_cnt), 0);
        check("rst_busy",   int'(obusy), 0);
        tick();
        irst_n = 1'b1;

        // First strobe only leaves IDLE.
        strobe(1'b1);
        post_strobe("open", 1'b0);

        for (int i = 0; i < 10; i++) begin
            pixels(tbl[i].lo, tbl[i].hi, tbl[i].npx);
            if (tbl[i].pub)
                sb_q.push_back('{tbl[i].exp_min, tbl[i].exp_rng});
            strobe(tbl[i].en);
            post_strobe($sformatf("f%0d", i), tbl[i].pub);
        end
        check("tbl_drop", int'(odrop_cnt), 0);

        // Offer held (ack low) while further frames close.
        iparam_ack = 1'b0;
        pixels(50, 150, 64);
        sb_q.push_back('{92, 25});
        strobe(1'b1);
        @(negedge isrc_clk);
        @(negedge isrc_clk);
        check("hold_valid", int'(oparam_valid), 1);
        check("hold_busy",  int'(obusy), 1);
        strobe(1'b1);
        strobe(1'b1);
        @(negedge isrc_clk);
        check("hold_drop2",  int'(odrop_cnt), 2);
        check("hold_valid2", int'(oparam_valid), 1);
        check("hold_omin",   int'(omin), 92);
        check("hold_orange", int'(orange), 25);

        // Strobe on the transfer edge counts as a drop.
        tick();
        isrc_vs    = 1'b1;
        iparam_ack = 1'b1;
        tick();
        isrc_vs    = 1'b0;
        iparam_ack = 1'b0;
        @(negedge isrc_clk);
        check("xfer_drop",   int'(odrop_cnt), 3);
        check("xfer_valid",  int'(oparam_valid), 0);
        check("xfer_busy",   int'(obusy), 0);
        check("xfer_omin",   int'(omin), 92);
        check("xfer_orange", int'(orange), 25);

        // Drop counter saturation, then reset while offering.
        pixels(60, 60, 20);
        strobe(1'b1);
        @(negedge isrc_clk);
        @(negedge isrc_clk);
        check("sat_valid",  int'(oparam_valid), 1);
        check("sat_omin",   int'(omin), 84);
        check("sat_orange", int'(orange), 18);
        for (int k = 0; k < 260; k++)
            strobe(1'b1);
        @(negedge isrc_clk);
        check("sat_drop",   int'(odrop_cnt), 255);
        check("sat_omin2",  int'(omin), 84);

        @(posedge isrc_clk);
        #3;
        irst_n = 1'b0;
        #1;
        check("arst_valid",  int'(oparam_valid), 0);
        check("arst_drop",   int'(odrop_cnt), 0);
        check("arst_omin",   int'(omin), 0);
        check("arst_orange", int'(orange), 1);
        check("arst_busy",   int'(obusy), 0);
        tick();
        irst_n     = 1'b1;
        iparam_ack = 1'b1;

        // Post-reset: history cleared, first commit loads directly.
        strobe(1'b1);
        post_strobe("reopen", 1'b0);
        pixels(30, 90, 20);
        sb_q.push_back('{30, 60});
        strobe(1'b1);
        post_strobe("after_rst", 1'b1);

        @(negedge isrc_clk);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
